// File: rtl/tick_sequencer.sv
// Programmable-rate tick generator: emits one-cycle enable pulses at one of four
// divisor rates, either continuously until stopped or as a counted burst ending in done.
module tick_sequencer #(
    parameter int          CNT_W   = 28,
    parameter int unsigned RATE_0  = 1_999_999,
    parameter int unsigned RATE_1  = 299_999,
    parameter int unsigned RATE_2  = 99_999_999,
    parameter int unsigned RATE_3  = 199_999_999,
    parameter int          BURST_W = 4
) (
    input  logic               clock,
    input  logic               Clear_b,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [1:0]         rate_sel,
    input  logic [BURST_W-1:0] burst_len,
    output logic               tick,
    output logic               busy,
    output logic               done,
    output logic [BURST_W-1:0] tick_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   q, q_next;
    logic [BURST_W-1:0] count_next;
    logic               mode_lat, mode_next;
    logic [BURST_W-1:0] len_lat, len_next;
    logic [CNT_W-1:0]   rate_val;
    logic               zero_burst;

    always_comb begin
        rate_val = CNT_W'(RATE_0);
        case (rate_sel)
            2'd0:    rate_val = CNT_W'(RATE_0);
            2'd1:    rate_val = CNT_W'(RATE_1);
            2'd2:    rate_val = CNT_W'(RATE_2);
            default: rate_val = CNT_W'(RATE_3);
        endcase
    end

    // A zero-length burst terminates immediately and must never produce a tick,
    // even when the selected divisor is zero.
    assign zero_burst = mode_lat && (len_lat == '0);

    always_ff @(posedge clock or negedge Clear_b) begin
        if (!Clear_b) begin
            state      <= IDLE;
            q          <= '0;
            tick_count <= '0;
            mode_lat   <= 1'b0;
            len_lat    <= '0;
        end else begin
            state      <= state_next;
            q          <= q_next;
            tick_count <= count_next;
            mode_lat   <= mode_next;
            len_lat    <= len_next;
        end
    end

    always_comb begin
        state_next = state;
        q_next     = q;
        count_next = tick_count;
        mode_next  = mode_lat;
        len_next   = len_lat;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_next = RUN;
                    q_next     = rate_val;
                    mode_next  = mode;
                    len_next   = burst_len;
                    count_next = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (zero_burst) begin
                    state_next = DONE;
                end else if (q != '0) begin
                    q_next = q - CNT_W'(1);
                end else begin
                    // Reloading from the live rate_sel means a rate change lands on a period boundary.
                    count_next = tick_count + BURST_W'(1);
                    q_next     = rate_val;
                    if (mode_lat && (count_next == len_lat)) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign tick = (state == RUN) && (q == '0) && !stop && !zero_burst;
    assign busy = (state == RUN) || (state == DONE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_tick_sequencer.sv
// Randomised scoreboard bench for tick_sequencer; expected outputs come from an
// absolute-cycle schedule model and are checked by an independent monitor.
module tb_tick_sequencer;

    logic       clock;
    logic       Clear_b;
    logic       start;
    logic       stop;
    logic       mode;
    logic [1:0] rate_sel;
    logic [3:0] burst_len;
    logic       tick;
    logic       busy;
    logic       done;
    logic [3:0] tick_count;

    tick_sequencer #(
        .CNT_W  (8),
        .RATE_0 (3),
        .RATE_1 (0),
        .RATE_2 (5),
        .RATE_3 (1),
        .BURST_W(4)
    ) dut (
        .clock     (clock),
        .Clear_b   (Clear_b),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .rate_sel  (rate_sel),
        .burst_len (burst_len),
        .tick      (tick),
        .busy      (busy),
        .done      (done),
        .tick_count(tick_count)
    );

    typedef struct {
        int         cyc;
        logic       tick;
        logic       busy;
        logic       done;
        logic [3:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    int rates[4] = '{3, 0, 5, 1};

    // Model: a run is a schedule of absolute tick cycles rather than a counter.
    bit m_run   = 0;
    bit m_done  = 0;
    bit m_mode  = 0;
    int m_len   = 0;
    int m_count = 0;
    int m_next  = 0;
    int cyc     = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic apply_stimulus(input bit s, input bit st, input bit m, input int rs,
                                  input int bl, input bit rst_b);
        exp_t e;
        @(posedge clock);
        #1;
        Clear_b   = rst_b;
        start     = s;
        stop      = st;
        mode      = m;
        rate_sel  = 2'(rs);
        burst_len = 4'(bl);
        e.cyc = cyc;
        if (!rst_b) begin
            e.tick = 0; e.busy = 0; e.done = 0; e.cnt = 4'd0;
            m_run = 0; m_done = 0; m_mode = 0; m_len = 0; m_count = 0;
        end else begin
            e.busy = m_run || m_done;
            e.done = m_done;
            e.cnt  = 4'(m_count);
            e.tick = m_run && (cyc == m_next) && !st && !(m_mode && m_len == 0);
            if (m_done) begin
                m_done = 0;
            end else if (m_run) begin
                if (st) begin
                    m_run = 0;
                end else if (m_mode && m_len == 0) begin
                    m_run = 0; m_done = 1;
                end else if (cyc == m_next) begin
                    m_count = (m_count + 1) % 16;
                    m_next  = cyc + rates[rs] + 1;
                    if (m_mode && m_count == m_len) begin
                        m_run = 0; m_done = 1;
                    end
                end
            end else if (s && !st) begin
                m_run = 1; m_mode = m; m_len = bl; m_count = 0;
                m_next = cyc + 1 + rates[rs];
            end
        end
        cyc++;
        exp_q.push_back(e);
    endtask

    task automatic idle_cycles(input int n, input int rs);
        for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, rs, 0, 1);
    endtask

    task automatic check_output(input string name, input int act, input int req, input int at);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, at, act, req);
        end
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_output("tick", int'(tick), int'(e.tick), e.cyc);
            check_output("busy", int'(busy), int'(e.busy), e.cyc);
            check_output("done", int'(done), int'(e.done), e.cyc);
            check_output("tick_count", int'(tick_count), int'(e.cnt), e.cyc);
        end
    end

    initial begin
        Clear_b = 0; start = 0; stop = 0; mode = 0; rate_sel = 0; burst_len = 0;
        for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 0, 0, 0, 0);
        idle_cycles(2, 0);

        // Periodic run at rate 0 for 16 cycles, then stop.
        apply_stimulus(1, 0, 0, 0, 0, 1);
        idle_cycles(16, 0);
        apply_stimulus(0, 1, 0, 0, 0, 1);
        idle_cycles(2, 0);

        // Burst of three, then a held count in IDLE.
        apply_stimulus(1, 0, 1, 0, 3, 1);
        idle_cycles(17, 0);

        // Zero-length burst, then a two-tick burst at divisor 0.
        apply_stimulus(1, 0, 1, 0, 0, 1);
        idle_cycles(4, 0);
        apply_stimulus(1, 0, 1, 1, 2, 1);
        idle_cycles(5, 1);

        // Rate change at cycle 5 to rate 2.
        apply_stimulus(1, 0, 0, 0, 0, 1);
        idle_cycles(5, 0);
        idle_cycles(16, 2);
        apply_stimulus(0, 1, 0, 2, 0, 1);
        idle_cycles(2, 0);

        // Stop coinciding with the tick at cycle 7.
        apply_stimulus(1, 0, 0, 0, 0, 1);
        idle_cycles(7, 0);
        apply_stimulus(0, 1, 0, 0, 0, 1);
        idle_cycles(3, 0);

        // start and stop together in IDLE.
        apply_stimulus(1, 1, 0, 0, 0, 1);
        idle_cycles(4, 0);

        // Asynchronous reset mid-burst, then a periodic run with an ignored start.
        apply_stimulus(1, 0, 1, 0, 5, 1);
        idle_cycles(9, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        idle_cycles(1, 0);
        apply_stimulus(1, 0, 0, 0, 0, 1);
        idle_cycles(5, 0);
        apply_stimulus(1, 0, 1, 2, 1, 1);
        idle_cycles(10, 0);
        apply_stimulus(0, 1, 0, 0, 0, 1);
        idle_cycles(2, 0);

        for (int i = 0; i < 3000; i++) begin
            bit s, st, m, rb;
            int rs, bl;
            s  = ($urandom_range(0, 7) == 0);
            st = ($urandom_range(0, 39) == 0);
            m  = $urandom_range(0, 1) == 1;
            rs = (i / 23) % 4;
            if ($urandom_range(0, 9) == 0) rs = $urandom_range(0, 3);
            bl = $urandom_range(0, 15);
            rb = ($urandom_range(0, 299) != 0);
            apply_stimulus(s, st, m, rs, bl, rb);
        end

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(negedge clock);
            #1;
        end
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tick_sequencer.md
# tick_sequencer

Parametrised, programmable-rate tick generator that produces one-cycle enable pulses for the dice-roll animation and the piece-drawing sequencer. It replaces the fixed-rate divider with four parameterised rates, a configurable counter width, start/stop control, and a burst mode that emits exactly N ticks and then signals completion. It sits between the game controller, which issues start/stop, and the dice/draw datapaths, which consume `tick` as a clock enable.

## Interface
- `CNT_W`, 28: down-counter width; every `RATE_k` must fit in `CNT_W` bits.
- `RATE_0`, 1_999_999: divisor for `rate_sel`=0 (dice roll); tick period = `RATE_0`+1 cycles.
- `RATE_1`, 299_999: divisor for `rate_sel`=1 (piece drawing).
- `RATE_2`, 99_999_999: divisor for `rate_sel`=2.
- `RATE_3`, 199_999_999: divisor for `rate_sel`=3.
- `BURST_W`, 4: width of `burst_len` and `tick_count`.

Ports:
- `clock`, in, 1: single system clock; all logic is on the rising edge.
- `Clear_b`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: begin a run; sampled only in IDLE.
- `stop`, in, 1: abort the current run; sampled in RUN and in IDLE.
- `mode`, in, 1: 0 = periodic (run until `stop`), 1 = burst (run for `burst_len` ticks); latched at start.
- `rate_sel`, in, 2: selects the `RATE_k` divisor; sampled at start and at every reload.
- `burst_len`, in, `BURST_W`: number of ticks in burst mode; latched at start.
- `tick`, out, 1: one-cycle enable pulse.
- `busy`, out, 1: high in the RUN and DONE states.
- `done`, out, 1: one-cycle pulse at the end of a burst.
- `tick_count`, out, `BURST_W`: number of ticks emitted in the current run.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE:
    - `start`=1 and `stop`=0: load `q`=RATE[`rate_sel`], latch `mode` and `burst_len`, clear `tick_count`, then go to RUN.
    - `stop` has priority: `start` and `stop` together leave the block in IDLE.
  - RUN, in priority order:
    - `stop`=1 goes to IDLE. No tick and no `done` in that cycle; `tick_count` holds its value.
    - Burst mode with latched `burst_len`=0 goes to DONE on the first RUN edge. No tick is emitted.
    - `q`≠0: decrement `q`.
    - `q`=0: `tick` is high in this cycle; increment `tick_count` (it wraps modulo 2^`BURST_W` in periodic mode). Reload `q` from the current `rate_sel`, so a rate change takes effect only at a period boundary.
      - If burst mode and the incremented count equals `burst_len`, go to DONE.
  - DONE: `done`=1 for exactly one cycle, then go to IDLE. `start` is ignored in DONE.
- `start` in RUN or DONE is ignored; there is no queuing.
- `tick` = (state==RUN) & (`q`==0) & ~`stop`. This is the only output with an input in its path (`stop`).
- `busy` and `done` are decoded from the state register only.
- `tick_count` holds its final value in IDLE until the next accepted start.
- `RATE_k`=0 gives a tick on every RUN cycle.

## Timing
- Reset (`Clear_b`=0, asynchronous): state=IDLE, `q`=0, `tick_count`=0, latched `mode`/`burst_len`=0. Outputs `tick`=`busy`=`done`=0 immediately.
- Release of reset is synchronous to the next `clock` edge.
- Reset asserted mid-run aborts the run with no `done` pulse.
- Cycle numbering: start is accepted at edge 0, so cycle 0 is the first RUN cycle and `busy` is high from cycle 0.
  - With divisor D, ticks occur at cycles D, 2D+1, 3D+2, … (period D+1).
- Burst of N ticks: the last tick is at cycle N·(D+1)−1, `done` is high at cycle N·(D+1), and `busy` falls at cycle N·(D+1)+1.
- `burst_len`=0: `done` is high at cycle 1 and `busy` is low from cycle 2.
- `stop` sampled high at edge k (state RUN): `tick` is masked in cycle k−1 if it coincides, and `busy`=0 from cycle k.
- A restart is accepted earliest in the first IDLE cycle.

## Test plan
Use `RATE_0`=3, `RATE_1`=0, `RATE_2`=5, `RATE_3`=1, `BURST_W`=4 for all scenarios.
- **Periodic run:** start with `mode`=0, `rate_sel`=0 at edge 0 → `tick` at cycles 3, 7, 11, 15; `tick_count` reads 1, 2, 3, 4 after each; `busy` is continuously high.
- **Burst:** start with `mode`=1, `burst_len`=3, `rate_sel`=0 → ticks at cycles 3, 7, 11; `done` at cycle 12 only; `busy` low at cycle 13; `tick_count`=3 held in IDLE.
- **Edge cases:** `burst_len`=0 → no tick, `done` at cycle 1. `rate_sel`=1 with `burst_len`=2 → ticks at cycles 0 and 1, `done` at cycle 2.
- **Rate change:** periodic run at `rate_sel`=0; switch to `rate_sel`=2 at cycle 5 → next tick at cycle 7 (old period completes), then at 13 and 19.
- **Stop:** `stop`=1 in the same cycle as a tick (cycle 7) → no tick, no `done`, `busy`=0 at cycle 8. `start`+`stop` together in IDLE → the block stays IDLE.
- **Async reset:** `Clear_b` pulsed low mid-burst between edges → `busy`/`tick`/`done`/`tick_count` go to 0 without a clock edge. After release, a new start behaves as in the periodic scenario. `start` during RUN is ignored (tick spacing unchanged).
